// File: rtl/irrigation_pkg.sv
// Shared state encoding, valve modes and drain rates for the multi-zone
// irrigation controller and its round-robin arbiter.
package irrigation_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FILL     = 3'd1,
    IRRIGATE = 3'd2,
    CLEAN    = 3'd3,
    ERROR    = 3'd4
  } irr_state_e;

  localparam logic MODE_DRIP      = 1'b0;
  localparam logic MODE_SPRINKLER = 1'b1;

  localparam int DRAIN_DRIP      = 32'sd1;
  localparam int DRAIN_SPRINKLER = 32'sd2;

  // Zone index addition modulo n, for operands already in 0..n-1.
  function automatic int wrap_add(input int a, input int b, input int n);
    int s;
    s = a + b;
    if (s >= n) begin
      return s - n;
    end else begin
      return s;
    end
  endfunction

endpackage

// File: rtl/multi_zone_irrigation_ctrl_if.sv
// Zone request / valve / display bundle between the environment (master)
// and the irrigation controller (slave).
interface multi_zone_irrigation_ctrl_if #(
  parameter int N_ZONES = 4,
  parameter int LEVEL_W = 3
);

  logic                       tick;
  logic [N_ZONES-1:0]         asp;
  logic [N_ZONES-1:0]         got;
  logic                       adb;
  logic                       ve;
  logic [N_ZONES-1:0]         valve_en;
  logic                       valve_mode;
  logic [LEVEL_W-1:0]         level;
  logic [2:0]                 state;
  logic                       clean;
  logic                       erro;
  logic [$clog2(N_ZONES)-1:0] err_zone;

  modport master (
    output tick, asp, got, adb,
    input  ve, valve_en, valve_mode, level, state, clean, erro, err_zone
  );

  modport slave (
    input  tick, asp, got, adb,
    output ve, valve_en, valve_mode, level, state, clean, erro, err_zone
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin zone picker: the first requesting zone at or
// after rr_ptr_i, wrapping past the last zone.
module rr_arbiter
  import irrigation_pkg::*;
#(
  parameter int N_ZONES = 4
) (
  input  logic [N_ZONES-1:0]         req_i,
  input  logic [$clog2(N_ZONES)-1:0] rr_ptr_i,
  output logic [$clog2(N_ZONES)-1:0] grant_o,
  output logic                       grant_valid_o
);

  localparam int ZW = $clog2(N_ZONES);

  logic [ZW-1:0] idx_s;

  assign grant_valid_o = |req_i;

  // Walk offsets from farthest to nearest so the nearest requester is kept.
  always_comb begin
    grant_o = '0;
    idx_s   = '0;
    for (int k = N_ZONES - 1; k >= 0; k--) begin
      idx_s   = ZW'(wrap_add(int'(rr_ptr_i), k, N_ZONES));
      grant_o = req_i[idx_s] ? idx_s : grant_o;
    end
  end

endmodule

// File: rtl/multi_zone_irrigation_ctrl.sv
// Multi-zone irrigation controller: tank fill, round-robin zone sessions,
// post-fertiliser cleaning and a latched input-conflict error.
module multi_zone_irrigation_ctrl
  import irrigation_pkg::*;
#(
  parameter int N_ZONES      = 4,
  parameter int LEVEL_W      = 3,
  parameter int LOW_THR      = 2,
  parameter int CLEAN_CYCLES = 3
) (
  input logic                         clock,
  input logic                         reset,
  multi_zone_irrigation_ctrl_if.slave bus
);

  localparam int ZW = $clog2(N_ZONES);
  localparam int CW = $clog2(CLEAN_CYCLES + 1);

  localparam logic [LEVEL_W-1:0] LEVEL_MAX = {LEVEL_W{1'b1}};
  localparam logic [LEVEL_W-1:0] LEVEL_ONE = LEVEL_W'(32'd1);
  localparam logic [LEVEL_W-1:0] LEVEL_LOW = LEVEL_W'(LOW_THR);
  localparam logic [LEVEL_W-1:0] RATE_DRIP = LEVEL_W'(DRAIN_DRIP);
  localparam logic [LEVEL_W-1:0] RATE_SPRK = LEVEL_W'(DRAIN_SPRINKLER);
  localparam logic [CW-1:0]      CNT_ONE   = CW'(32'd1);
  localparam logic [CW-1:0]      CNT_LAST  = CW'(CLEAN_CYCLES - 1);
  localparam logic [N_ZONES-1:0] ZONE_ONE  = N_ZONES'(32'd1);

  irr_state_e         state_q, state_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [ZW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [ZW-1:0]      grant_q, grant_d;
  logic [ZW-1:0]      err_zone_q, err_zone_d;
  logic               mode_q, mode_d;
  logic               fert_q, fert_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic               ve_q, ve_d;
  logic [N_ZONES-1:0] valve_en_q, valve_en_d;
  logic               valve_mode_q, valve_mode_d;
  logic               clean_q, clean_d;
  logic               erro_q, erro_d;

  logic [N_ZONES-1:0] req_s, conflict_s;
  logic [ZW-1:0]      arb_grant_s, conf_zone_s;
  logic               arb_valid_s;
  logic [LEVEL_W-1:0] rate_s, drained_s;

  assign req_s      = bus.asp | bus.got;
  assign conflict_s = bus.asp & bus.got;

  rr_arbiter #(
    .N_ZONES(N_ZONES)
  ) u_arb (
    .req_i        (req_s),
    .rr_ptr_i     (rr_ptr_q),
    .grant_o      (arb_grant_s),
    .grant_valid_o(arb_valid_s)
  );

  // Lowest conflicting zone index, reported when the error latches.
  always_comb begin
    conf_zone_s = '0;
    for (int i = N_ZONES - 1; i >= 0; i--) begin
      conf_zone_s = conflict_s[i] ? ZW'(i) : conf_zone_s;
    end
  end

  assign rate_s    = (mode_q == MODE_SPRINKLER) ? RATE_SPRK : RATE_DRIP;
  assign drained_s = (level_q > rate_s) ? (level_q - rate_s) : '0;

  // Next-state, datapath and Moore output decode.
  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    err_zone_d = err_zone_q;
    mode_d     = mode_q;
    fert_d     = fert_q;
    cnt_d      = cnt_q;

    if (state_q == ERROR) begin
      state_d = ERROR;
    end else if (|conflict_s) begin
      state_d    = ERROR;
      err_zone_d = conf_zone_s;
    end else begin
      case (state_q)
        IDLE: begin
          fert_d = 1'b0;
          if (level_q == '0) begin
            state_d = FILL;
          end else if (arb_valid_s && (level_q >= LEVEL_LOW)) begin
            state_d  = IRRIGATE;
            grant_d  = arb_grant_s;
            mode_d   = bus.asp[arb_grant_s];
            rr_ptr_d = ZW'(wrap_add(int'(arb_grant_s), 32'sd1, N_ZONES));
          end else if (arb_valid_s) begin
            state_d = FILL;
          end else begin
            state_d = IDLE;
          end
        end
        FILL: begin
          if (level_q == LEVEL_MAX) begin
            state_d = IDLE;
          end else if (bus.tick) begin
            level_d = level_q + LEVEL_ONE;
          end else begin
            level_d = level_q;
          end
        end
        IRRIGATE: begin
          // A fertiliser request in the closing cycle still forces a clean.
          fert_d = fert_q | (bus.adb & (mode_q == MODE_SPRINKLER));
          if (!req_s[grant_q] || (level_q == '0)) begin
            state_d = fert_d ? CLEAN : IDLE;
          end else if (bus.tick) begin
            level_d = drained_s;
          end else begin
            level_d = level_q;
          end
        end
        CLEAN: begin
          if (bus.tick) begin
            if (cnt_q == CNT_LAST) begin
              cnt_d   = '0;
              state_d = IDLE;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        default: begin
          state_d = ERROR;
        end
      endcase
    end

    ve_d         = (state_d == FILL);
    valve_en_d   = (state_d == IRRIGATE) ? (ZONE_ONE << grant_d) : '0;
    valve_mode_d = (state_d == IRRIGATE) && mode_d;
    clean_d      = (state_d == CLEAN);
    erro_d       = (state_d == ERROR);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      level_q      <= '0;
      rr_ptr_q     <= '0;
      grant_q      <= '0;
      err_zone_q   <= '0;
      mode_q       <= MODE_DRIP;
      fert_q       <= 1'b0;
      cnt_q        <= '0;
      ve_q         <= 1'b0;
      valve_en_q   <= '0;
      valve_mode_q <= 1'b0;
      clean_q      <= 1'b0;
      erro_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_q      <= grant_d;
      err_zone_q   <= err_zone_d;
      mode_q       <= mode_d;
      fert_q       <= fert_d;
      cnt_q        <= cnt_d;
      ve_q         <= ve_d;
      valve_en_q   <= valve_en_d;
      valve_mode_q <= valve_mode_d;
      clean_q      <= clean_d;
      erro_q       <= erro_d;
    end
  end

  assign bus.ve         = ve_q;
  assign bus.valve_en   = valve_en_q;
  assign bus.valve_mode = valve_mode_q;
  assign bus.level      = level_q;
  assign bus.state      = state_q;
  assign bus.clean      = clean_q;
  assign bus.erro       = erro_q;
  assign bus.err_zone   = err_zone_q;

endmodule

// File: tb/tb_multi_zone_irrigation_ctrl.sv
// Bench for multi_zone_irrigation_ctrl: fixed vector table, directed corner
// sequences and random traffic against a behavioural reference model.
module tb_multi_zone_irrigation_ctrl;

  localparam int M_IDLE = 0;
  localparam int M_FILL = 1;
  localparam int M_IRR  = 2;
  localparam int M_CLN  = 3;
  localparam int M_ERR  = 4;
  localparam int NZ     = 4;
  localparam int LMAX   = 7;
  localparam int LOW    = 2;
  localparam int NCLEAN = 3;

  logic clock = 1'b0;
  logic reset;

  multi_zone_irrigation_ctrl_if #(.N_ZONES(4), .LEVEL_W(3)) bus ();

  multi_zone_irrigation_ctrl #(
    .N_ZONES(4), .LEVEL_W(3), .LOW_THR(2), .CLEAN_CYCLES(3)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int m_st = 0, m_lvl = 0, m_ptr = 0, m_zone = 0, m_ez = 0, m_cnt = 0;
  bit m_mode = 1'b0, m_fert = 1'b0;

  typedef struct {
    bit       rst;
    bit [3:0] asp;
    bit [3:0] got;
    bit       adb;
    bit [2:0] st;
    bit [2:0] lvl;
    bit       ve;
    bit [3:0] ven;
    bit       vm;
    bit       cl;
    bit       er;
    bit [1:0] ez;
  } vec_t;

  vec_t tbl[$];

  task automatic add_row(input bit rst, input bit [3:0] a, input bit [3:0] g, input bit f,
                         input bit [2:0] st, input bit [2:0] lvl, input bit ve, input bit [3:0] ven,
                         input bit vm, input bit cl, input bit er, input bit [1:0] ez);
    vec_t v;
    v.rst = rst; v.asp = a; v.got = g; v.adb = f;
    v.st = st; v.lvl = lvl; v.ve = ve; v.ven = ven; v.vm = vm; v.cl = cl; v.er = er; v.ez = ez;
    tbl.push_back(v);
  endtask

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] dut_pack();
    return {bus.state, bus.level, bus.ve, bus.valve_en, bus.valve_mode, bus.clean, bus.erro, bus.err_zone};
  endfunction

  function automatic logic [15:0] model_pack();
    logic [3:0] ven;
    logic [2:0] st3;
    logic [2:0] lv3;
    logic [1:0] ez2;
    ven = (m_st == M_IRR) ? (4'b0001 << m_zone) : 4'b0000;
    st3 = 3'(m_st);
    lv3 = 3'(m_lvl);
    ez2 = 2'(m_ez);
    return {st3, lv3, (m_st == M_FILL), ven, ((m_st == M_IRR) && m_mode),
            (m_st == M_CLN), (m_st == M_ERR), ez2};
  endfunction

  // Rules of the controller, one clock at a time.
  task automatic model_step(input bit rst, input bit tk, input bit [3:0] a, input bit [3:0] g, input bit f);
    bit [3:0] req, conf;
    int rate;
    req = a | g;
    conf = a & g;
    if (rst) begin
      m_st = M_IDLE; m_lvl = 0; m_ptr = 0; m_zone = 0; m_ez = 0; m_cnt = 0;
      m_mode = 1'b0; m_fert = 1'b0;
      return;
    end
    if (m_st == M_ERR) return;
    if (conf != 4'b0000) begin
      m_st = M_ERR;
      for (int i = NZ - 1; i >= 0; i--) if (conf[i]) m_ez = i;
      return;
    end
    case (m_st)
      M_IDLE: begin
        m_fert = 1'b0;
        if (m_lvl == 0 || (req != 4'b0000 && m_lvl < LOW)) m_st = M_FILL;
        else if (req != 4'b0000) begin
          for (int k = 0; k < NZ; k++) begin
            if (req[(m_ptr + k) % NZ]) begin
              m_zone = (m_ptr + k) % NZ;
              break;
            end
          end
          m_mode = a[m_zone];
          m_ptr = (m_zone + 1) % NZ;
          m_st = M_IRR;
        end
      end
      M_FILL: begin
        if (m_lvl == LMAX) m_st = M_IDLE;
        else if (tk) m_lvl = m_lvl + 1;
      end
      M_IRR: begin
        if (f && m_mode) m_fert = 1'b1;
        rate = m_mode ? 2 : 1;
        if (!req[m_zone] || m_lvl == 0) m_st = m_fert ? M_CLN : M_IDLE;
        else if (tk) m_lvl = (m_lvl > rate) ? m_lvl - rate : 0;
      end
      M_CLN: begin
        if (tk) begin
          m_cnt = m_cnt + 1;
          if (m_cnt == NCLEAN) begin
            m_cnt = 0;
            m_st = M_IDLE;
          end
        end
      end
      default: ;
    endcase
  endtask

  task automatic step(input bit rst, input bit tk, input bit [3:0] a, input bit [3:0] g, input bit f,
                      input string nm);
    reset = rst; bus.tick = tk; bus.asp = a; bus.got = g; bus.adb = f;
    @(posedge clock);
    #1;
    model_step(rst, tk, a, g, f);
    check(nm, dut_pack(), model_pack());
  endtask

  initial begin
    logic [3:0] first_g, second_g, last_en;
    int grants;
    bit [3:0] ra, rg;
    bit rf, rt, rr;

    reset = 1'b1; bus.tick = 1'b0; bus.asp = 4'b0000; bus.got = 4'b0000; bus.adb = 1'b0;

    // reset, fill to full, drip session on zone 2, fertilised sprinkler session on zone 0
    add_row(1'b1, 4'h0, 4'h0, 1'b0, 3'd0, 3'd0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0);
    add_row(1'b0, 4'h0, 4'h0, 1'b0, 3'd1, 3'd0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0);
    for (int i = 1; i <= 7; i++)
      add_row(1'b0, 4'h0, 4'h0, 1'b0, 3'd1, 3'(i), 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0);
    add_row(1'b0, 4'h0, 4'h0, 1'b0, 3'd0, 3'd7, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0);
    add_row(1'b0, 4'h0, 4'h0, 1'b0, 3'd0, 3'd7, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0);
    add_row(1'b0, 4'h0, 4'h4, 1'b0, 3'd2, 3'd7, 1'b0, 4'h4, 1'b0, 1'b0, 1'b0, 2'd0);
    add_row(1'b0, 4'h0, 4'h4, 1'b0, 3'd2, 3'd6, 1'b0, 4'h4, 1'b0, 1'b0, 1'b0, 2'd0);
    add_row(1'b0, 4'h0, 4'h4, 1'b0, 3'd2, 3'd5, 1'b0, 4'h4, 1'b0, 1'b0, 1'b0, 2'd0);
    add_row(1'b0, 4'h0, 4'h4, 1'b0, 3'd2, 3'd4, 1'b0, 4'h4, 1'b0, 1'b0, 1'b0, 2'd0);
    add_row(1'b0, 4'h0, 4'h0, 1'b0, 3'd0, 3'd4, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0);
    add_row(1'b0, 4'h1, 4'h0, 1'b1, 3'd2, 3'd4, 1'b0, 4'h1, 1'b1, 1'b0, 1'b0, 2'd0);
    add_row(1'b0, 4'h1, 4'h0, 1'b1, 3'd2, 3'd2, 1'b0, 4'h1, 1'b1, 1'b0, 1'b0, 2'd0);
    add_row(1'b0, 4'h0, 4'h0, 1'b0, 3'd3, 3'd2, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 2'd0);
    add_row(1'b0, 4'h0, 4'h0, 1'b0, 3'd3, 3'd2, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 2'd0);
    add_row(1'b0, 4'h0, 4'h0, 1'b0, 3'd3, 3'd2, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 2'd0);
    add_row(1'b0, 4'h0, 4'h0, 1'b0, 3'd0, 3'd2, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0);

    foreach (tbl[i]) begin
      step(tbl[i].rst, 1'b1, tbl[i].asp, tbl[i].got, tbl[i].adb, "table model");
      check($sformatf("table row %0d", i), dut_pack(),
            {tbl[i].st, tbl[i].lvl, tbl[i].ve, tbl[i].ven, tbl[i].vm, tbl[i].cl, tbl[i].er, tbl[i].ez});
    end

    // round-robin: zone 1 drains the tank, refill, then zone 3 gets its turn
    step(1'b1, 1'b1, 4'h0, 4'h0, 1'b0, "rr reset");
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 4'h0, 4'h0, 1'b0, "rr fill");
    check("rr full level", 16'(bus.level), 16'd7);
    grants = 0; first_g = 4'h0; second_g = 4'h0; last_en = 4'h0;
    for (int c = 0; c < 40 && grants < 2; c++) begin
      step(1'b0, 1'b1, 4'b1010, 4'h0, 1'b0, "rr run");
      if (bus.valve_en != 4'h0 && bus.valve_en != last_en) begin
        grants++;
        if (grants == 1) first_g = bus.valve_en;
        else second_g = bus.valve_en;
      end
      last_en = bus.valve_en;
    end
    check("rr first grant", 16'(first_g), 16'h0002);
    check("rr second grant", 16'(second_g), 16'h0008);

    // conflict during a session latches ERROR until reset
    step(1'b1, 1'b1, 4'h0, 4'h0, 1'b0, "err reset");
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 4'h0, 4'h0, 1'b0, "err fill");
    step(1'b0, 1'b1, 4'b0010, 4'h0, 1'b0, "err grant");
    check("err zone1 open", 16'(bus.valve_en), 16'h0002);
    step(1'b0, 1'b1, 4'b0110, 4'b0100, 1'b0, "err conflict");
    check("err flag", 16'(bus.erro), 16'd1);
    check("err zone", 16'(bus.err_zone), 16'd2);
    check("err valves", 16'({bus.valve_en, bus.ve}), 16'd0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 4'h0, 4'h0, 1'b0, "err hold");
    check("err sticky state", 16'(bus.state), 16'd4);
    step(1'b1, 1'b1, 4'h0, 4'h0, 1'b0, "err clear");
    check("err cleared", 16'({bus.state, bus.erro}), 16'd0);

    // reset in the middle of a fill
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 4'h0, 4'h0, 1'b0, "midrst fill");
    check("midrst level before", 16'({bus.state, bus.level}), 16'({3'd1, 3'd4}));
    step(1'b1, 1'b1, 4'h0, 4'h0, 1'b0, "midrst reset");
    check("midrst all zero", dut_pack(), 16'h0000);
    step(1'b0, 1'b1, 4'h0, 4'h0, 1'b0, "midrst refill");
    check("midrst fill again", 16'({bus.state, bus.ve}), 16'({3'd1, 1'b1}));

    // random traffic with sticky requests, sparse conflicts and resets
    ra = 4'h0; rg = 4'h0; rf = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        ra = 4'($urandom);
        rg = 4'($urandom) & ~ra;
        if ($urandom_range(0, 40) == 0) rg = rg | ra;
        rf = ($urandom_range(0, 2) == 0);
      end
      rt = ($urandom_range(0, 3) != 0);
      rr = ($urandom_range(0, 150) == 0);
      step(rr, rt, ra, rg, rf, "random");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
